// File: rtl/pong_pkg.sv
// Shared definitions for the pong button conditioner: debounce state
// encoding, debounce length calculation and button bit positions.
`timescale 1ns/1ps
package pong_pkg;

  // Per-channel debounce states. Bit 1 set means the debounced level is high.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAIT_HI = 2'b01,
    HIGH    = 2'b10,
    WAIT_LO = 2'b11
  } btn_state_t;

  // Button bit positions inside btn_raw / btn_level and friends.
  localparam int BTN_U = 3;
  localparam int BTN_L = 2;
  localparam int BTN_R = 1;
  localparam int BTN_D = 0;

  // Number of clock cycles a new level must persist before it is accepted.
  function automatic int calc_cnt_max(input int clk_hz, input int debounce_ms);
    return (clk_hz / 1000) * debounce_ms;
  endfunction

endpackage

// File: rtl/pong_btn_chan.sv
// One button channel: two-flop synchronizer, debounce FSM with stability
// counter, arm flag and registered level/press/release outputs.
`timescale 1ns/1ps
module pong_btn_chan
  import pong_pkg::*;
#(
  parameter int CNT_MAX = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn_raw,
  output logic       o_level,
  output logic       o_press,
  output logic       o_release,
  output logic       o_press_cond,
  output btn_state_t o_state
);

  localparam int               CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic             r_s1;
  logic             r_s2;
  logic [1:0]       r_sync_vld;
  btn_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_armed;
  logic             r_press;
  logic             r_release;

  btn_state_t       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_cnt_last;
  logic             w_arm_set;
  logic             w_press_cond;
  logic             w_release_cond;

  // Synchronize the raw pin. r_sync_vld marks when r_s2 holds a real pin
  // sample rather than its reset value, so a button held through reset is
  // never mistaken for a released one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_sync_vld <= 2'b00;
    end else begin
      r_s1       <= i_btn_raw;
      r_s2       <= r_s1;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
    end
  end

  // Debounce state and stability counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign w_cnt_last = (r_cnt == CNT_LAST);

  // Next state, counter update and the edge conditions for pulses and arming.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_arm_set      = 1'b0;
    w_press_cond   = 1'b0;
    w_release_cond = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_s2) begin
          w_state_nxt = WAIT_HI;
          w_cnt_nxt   = '0;
        end else if (r_sync_vld[1]) begin
          w_arm_set = 1'b1;
        end
      end
      WAIT_HI: begin
        if (!r_s2) begin
          w_state_nxt = IDLE;
        end else if (w_cnt_last) begin
          w_state_nxt  = HIGH;
          w_press_cond = r_armed;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!r_s2) begin
          w_state_nxt = WAIT_LO;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_LO: begin
        if (r_s2) begin
          w_state_nxt = HIGH;
        end else if (w_cnt_last) begin
          w_state_nxt    = IDLE;
          w_release_cond = 1'b1;
          w_arm_set      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Arm flag latches once a genuine low has been seen; pulses are registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_armed   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      if (w_arm_set) begin
        r_armed <= 1'b1;
      end
      r_press   <= w_press_cond;
      r_release <= w_release_cond;
    end
  end

  assign o_level      = (r_state == HIGH) || (r_state == WAIT_LO);
  assign o_press      = r_press;
  assign o_release    = r_release;
  assign o_press_cond = w_press_cond;
  assign o_state      = r_state;

endmodule

// File: rtl/pong_btn_cond.sv
// Button conditioner for the pong game: N_BTN independent debounce channels
// plus a registered any-press pulse aligned with the per-channel press pulses.
`timescale 1ns/1ps
module pong_btn_cond
  import pong_pkg::*;
#(
  parameter int N_BTN       = 4,
  parameter int CLK_HZ      = 100_000_000,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_BTN-1:0]   btn_raw,
  output logic [N_BTN-1:0]   btn_level,
  output logic [N_BTN-1:0]   btn_press,
  output logic [N_BTN-1:0]   btn_release,
  output logic               any_press,
  output logic [2*N_BTN-1:0] dbg_state
);

  localparam int CNT_MAX = calc_cnt_max(CLK_HZ, DEBOUNCE_MS);

  if (CNT_MAX < 2) begin : g_cnt_max_check
    $error("pong_btn_cond: debounce length CNT_MAX must be at least 2");
  end

  logic [N_BTN-1:0] w_press_cond;
  logic             r_any_press;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
    btn_state_t w_state;

    pong_btn_chan #(
      .CNT_MAX (CNT_MAX)
    ) u_chan (
      .i_clk        (clk),
      .i_rst_n      (reset),
      .i_btn_raw    (btn_raw[gi]),
      .o_level      (btn_level[gi]),
      .o_press      (btn_press[gi]),
      .o_release    (btn_release[gi]),
      .o_press_cond (w_press_cond[gi]),
      .o_state      (w_state)
    );

    assign dbg_state[2*gi +: 2] = w_state;
  end

  // One pulse for any number of simultaneous armed presses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_any_press <= 1'b0;
    end else begin
      r_any_press <= |w_press_cond;
    end
  end

  assign any_press = r_any_press;

endmodule
